clint_smp: RTL and testbench

- Core-local interruptor placed directly upstream of the RV cluster.
- Holds the shared 64-bit mtime counter, one 64-bit mtimecmp per hart and one MSIP bit per hart.
- Drives the cluster's w_mtime, w_mtip[N_HARTS-1:0] and w_msip[N_HARTS-1:0] inputs.
- Accessed by the memory controller through a simple single-beat register bus (CLINT offset map).

---
 rtl/clint_smp_if.sv | 13 +
 rtl/clint_smp.sv | 136 +++++++++++++
 tb/tb_clint_smp.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/clint_smp_if.sv
// Single-beat register bus between the memory controller and the CLINT.
// Reads respond one cycle later with r_rvalid.
interface clint_smp_if;
  logic [15:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_we;
  logic        w_re;
  logic [31:0] r_rdata;
  logic        r_rvalid;

  modport master (output w_addr, w_wdata, w_we, w_re, input r_rdata, r_rvalid);
  modport slave  (input w_addr, w_wdata, w_we, w_re, output r_rdata, r_rvalid);
endinterface

// File: rtl/clint_smp.sv
// Core-local interruptor: shared prescaled mtime, per-hart mtimecmp/msip,
// registered mtip/msip/mtime outputs toward the RV cluster.
module clint_smp_hart (
  input  logic        gclk,
  input  logic        grst_n,
  input  logic        we_msip,
  input  logic        we_lo,
  input  logic        we_hi,
  input  logic [31:0] wdata,
  input  logic [63:0] mtime,
  output logic        msip,
  output logic [63:0] cmp,
  output logic        mtip
);
  logic        msip_q, msip_d;
  logic [63:0] cmp_q, cmp_d;
  logic        mtip_q, mtip_d;

  always_comb begin
    msip_d = msip_q;
    cmp_d  = cmp_q;
    if (we_msip) msip_d = wdata[0];
    if (we_lo)   cmp_d  = {cmp_q[63:32], wdata};
    if (we_hi)   cmp_d  = {wdata, cmp_q[31:0]};
    // Compare current register values, so mtip trails any change by a cycle.
    mtip_d = (mtime >= cmp_q);
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      msip_q <= 1'b0;
      cmp_q  <= '1;
      mtip_q <= 1'b0;
    end else begin
      msip_q <= msip_d;
      cmp_q  <= cmp_d;
      mtip_q <= mtip_d;
    end
  end

  assign msip = msip_q;
  assign cmp  = cmp_q;
  assign mtip = mtip_q;
endmodule

module clint_smp #(
  parameter int N_HARTS  = 2,
  parameter int TICK_DIV = 1
) (
  input  logic               CLK,
  input  logic               RST_X,
  clint_smp_if.slave         bus,
  output logic [63:0]        w_mtime,
  output logic [N_HARTS-1:0] w_mtip,
  output logic [N_HARTS-1:0] w_msip
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0]             presc_q, presc_d;
  logic                      tick;
  logic [63:0]               mtime_q, mtime_d;
  logic [31:0]               rdata_q, rdata_d;
  logic                      rvalid_q, rvalid_d;
  logic                      sel_mt_lo, sel_mt_hi;
  logic [N_HARTS-1:0]        sel_msip, sel_cmp_lo, sel_cmp_hi;
  logic [N_HARTS-1:0]        msip, mtip;
  logic [N_HARTS-1:0][63:0]  cmp;

  assign sel_mt_lo = (bus.w_addr[15:2] == 14'h2FFE);
  assign sel_mt_hi = (bus.w_addr[15:2] == 14'h2FFF);

  // Only decoded harts get a select; anything else falls through as unmapped.
  for (genvar h = 0; h < N_HARTS; h++) begin : g_hart
    assign sel_msip[h]   = (bus.w_addr[15:14] == 2'b00) && (bus.w_addr[13:2] == 12'(h));
    assign sel_cmp_lo[h] = (bus.w_addr[15:14] == 2'b01) && (bus.w_addr[13:3] == 11'(h)) && !bus.w_addr[2];
    assign sel_cmp_hi[h] = (bus.w_addr[15:14] == 2'b01) && (bus.w_addr[13:3] == 11'(h)) &&  bus.w_addr[2];

    clint_smp_hart u_hart (
      .gclk    (CLK),
      .grst_n  (RST_X),
      .we_msip (bus.w_we && sel_msip[h]),
      .we_lo   (bus.w_we && sel_cmp_lo[h]),
      .we_hi   (bus.w_we && sel_cmp_hi[h]),
      .wdata   (bus.w_wdata),
      .mtime   (mtime_q),
      .msip    (msip[h]),
      .cmp     (cmp[h]),
      .mtip    (mtip[h])
    );
  end

  always_comb begin
    tick    = (presc_q == PW'(TICK_DIV - 1));
    presc_d = tick ? '0 : presc_q + PW'(1);
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    // A write to either half wins over the increment, with no carry between halves.
    if (bus.w_we && sel_mt_lo) mtime_d = {mtime_q[63:32], bus.w_wdata};
    if (bus.w_we && sel_mt_hi) mtime_d = {bus.w_wdata, mtime_q[31:0]};
  end

  // Read mux sees pre-write state, so a same-cycle write is not forwarded.
  always_comb begin
    rvalid_d = bus.w_re;
    rdata_d  = rdata_q;
    if (bus.w_re) begin
      rdata_d = '0;
      if (sel_mt_lo) rdata_d = mtime_q[31:0];
      if (sel_mt_hi) rdata_d = mtime_q[63:32];
      for (int h = 0; h < N_HARTS; h++) begin
        if (sel_msip[h])   rdata_d = {31'b0, msip[h]};
        if (sel_cmp_lo[h]) rdata_d = cmp[h][31:0];
        if (sel_cmp_hi[h]) rdata_d = cmp[h][63:32];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      presc_q  <= '0;
      mtime_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      mtime_q  <= mtime_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign bus.r_rdata  = rdata_q;
  assign bus.r_rvalid = rvalid_q;
  assign w_mtime      = mtime_q;
  assign w_mtip       = mtip;
  assign w_msip       = msip;
endmodule

// File: tb/tb_clint_smp.sv
// Directed bench for clint_smp with N_HARTS=2, TICK_DIV=4.
// E in comments = posedges since reset release; mtime steps on edges where E%4==0.
module tb_clint_smp;
  logic        CLK = 1'b0;
  logic        RST_X;
  logic [63:0] w_mtime;
  logic [1:0]  w_mtip, w_msip;
  int          total = 0;
  int          bad   = 0;

  clint_smp_if bus ();

  clint_smp #(.N_HARTS(2), .TICK_DIV(4)) dut (
    .CLK     (CLK),
    .RST_X   (RST_X),
    .bus     (bus),
    .w_mtime (w_mtime),
    .w_mtip  (w_mtip),
    .w_msip  (w_msip)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    bus.w_addr = a; bus.w_wdata = d; bus.w_we = 1'b1;
    tick();
    bus.w_we = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a);
    bus.w_addr = a; bus.w_re = 1'b1;
    tick();
    bus.w_re = 1'b0;
  endtask

  initial begin
    RST_X = 1'b0;
    bus.w_addr = '0; bus.w_wdata = '0; bus.w_we = 1'b0; bus.w_re = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK); RST_X = 1'b1;                       // E=0

    chk("rst_mtime",  w_mtime, 64'd0);
    chk("rst_mtip",   64'(w_mtip), 64'd0);
    chk("rst_msip",   64'(w_msip), 64'd0);
    chk("rst_rvalid", 64'(bus.r_rvalid), 64'd0);
    chk("rst_rdata",  64'(bus.r_rdata), 64'd0);

    rd(16'h4004);                                       // E=1
    chk("rst_cmp_rvalid", 64'(bus.r_rvalid), 64'd1);
    chk("rst_cmp_rdata",  64'(bus.r_rdata), 64'hFFFF_FFFF);
    tick();                                             // E=2
    chk("rvalid_pulse", 64'(bus.r_rvalid), 64'd0);
    chk("rdata_hold",   64'(bus.r_rdata), 64'hFFFF_FFFF);

    repeat (37) tick();                                 // E=39
    chk("cnt_e39", w_mtime, 64'd9);
    tick();                                             // E=40
    chk("cnt_e40", w_mtime, 64'd10);
    tick();                                             // E=41
    chk("cnt_e41", w_mtime, 64'd10);

    wr(16'h400C, 32'd0);                                // E=42
    wr(16'h4008, 32'd20);                               // E=43
    repeat (37) tick();                                 // E=80, mtime just reached 20
    chk("mtip_mtime20", w_mtime, 64'd20);
    chk("mtip_lag",     64'(w_mtip), 64'd0);
    tick();                                             // E=81
    chk("mtip_rise",    64'(w_mtip), 64'b10);
    wr(16'h4008, 32'd1000);                             // E=82
    chk("mtip_still",   64'(w_mtip), 64'b10);
    tick();                                             // E=83
    chk("mtip_fall",    64'(w_mtip), 64'd0);

    wr(16'h0004, 32'hFFFF_FFFF);                        // E=84
    chk("msip_set", 64'(w_msip), 64'b10);
    rd(16'h0004);                                       // E=85
    chk("msip_rd",  64'(bus.r_rdata), 64'd1);
    wr(16'h0004, 32'd0);                                // E=86
    chk("msip_clr", 64'(w_msip), 64'd0);
    wr(16'h0008, 32'd1);                                // E=87, hart 2 unmapped
    chk("msip_unm", 64'(w_msip), 64'd0);
    rd(16'h0008);                                       // E=88
    chk("unm_rvalid", 64'(bus.r_rvalid), 64'd1);
    chk("unm_rdata",  64'(bus.r_rdata), 64'd0);

    wr(16'hBFFC, 32'hFFFF_FFFF);                        // E=89
    wr(16'hBFF8, 32'hFFFF_FFFE);                        // E=90
    chk("mt_written", w_mtime, 64'hFFFF_FFFF_FFFF_FFFE);
    repeat (2) tick();                                  // E=92
    chk("mt_allones", w_mtime, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();                                             // E=93
    chk("mtip_both",  64'(w_mtip), 64'b11);
    repeat (3) tick();                                  // E=96
    chk("mt_wrap",    w_mtime, 64'd0);
    tick();                                             // E=97
    chk("mtip_wrap",  64'(w_mtip), 64'd0);

    repeat (2) tick();                                  // E=99
    wr(16'hBFF8, 32'd5);                                // E=100, increment edge
    chk("coll_wr",    w_mtime, 64'd5);
    repeat (3) tick();                                  // E=103
    chk("coll_e103",  w_mtime, 64'd5);
    tick();                                             // E=104
    chk("coll_e104",  w_mtime, 64'd6);

    wr(16'h4000, 32'd7);                                // E=105
    bus.w_addr = 16'h4000; bus.w_wdata = 32'd9; bus.w_we = 1'b1; bus.w_re = 1'b1;
    tick();                                             // E=106
    bus.w_we = 1'b0; bus.w_re = 1'b0;
    chk("rw_rvalid", 64'(bus.r_rvalid), 64'd1);
    chk("rw_old",    64'(bus.r_rdata), 64'd7);
    rd(16'h4000);                                       // E=107
    chk("rw_new",    64'(bus.r_rdata), 64'd9);
    rd(16'h4010);                                       // E=108, mtimecmp[2] unmapped
    chk("cmp_unm",   64'(bus.r_rdata), 64'd0);

    // Reset in the middle of a read response.
    rd(16'h4000);
    chk("pre_rst_rvalid", 64'(bus.r_rvalid), 64'd1);
    RST_X = 1'b0; #1;
    chk("midrst_rvalid", 64'(bus.r_rvalid), 64'd0);
    chk("midrst_rdata",  64'(bus.r_rdata), 64'd0);
    chk("midrst_mtime",  w_mtime, 64'd0);
    @(negedge CLK); RST_X = 1'b1;
    rd(16'h4000);
    chk("midrst_cmp", 64'(bus.r_rdata), 64'hFFFF_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
